// File: rtl/dmem_wbuf_pkg.sv
// rtl/dmem_wbuf_pkg.sv - shared constants and types for the data-memory write buffer
// Purpose: store/no-op opcodes, buffer FSM state encoding and the entry record.
// The entry record is sized by WBUF_ADDR_W/WBUF_DATA_W; the top-level ADDR_W/DATA_W
// parameters default to these and must be changed together with them.
package dmem_wbuf_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_NONE  = 7'b0000000;

  localparam int WBUF_ADDR_W = 32;
  localparam int WBUF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2
  } wbuf_state_t;

  typedef struct packed {
    logic                   valid;
    logic [WBUF_ADDR_W-1:0] addr;
    logic [WBUF_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/wbuf_match.sv
// rtl/wbuf_match.sv - word-index comparator with newest-entry priority select
// Purpose: find the newest valid entry whose word index equals i_key.
// Ports:
//   i_valid  per-entry valid mask (may be pre-masked by the caller)
//   i_word   per-entry word index
//   i_tail   FIFO tail pointer; the entry just before tail is the newest
//   i_key    word index being looked up
//   o_hit    some masked entry matches
//   o_idx    slot of the newest matching entry (0 when no hit)
module wbuf_match #(
  parameter int DEPTH  = 4,
  parameter int WORD_W = 30,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             i_valid,
  input  logic [DEPTH-1:0][WORD_W-1:0] i_word,
  input  logic [PTR_W-1:0]             i_tail,
  input  logic [WORD_W-1:0]            i_key,
  output logic                         o_hit,
  output logic [PTR_W-1:0]             o_idx
);

  logic [PTR_W-1:0] w_slot;

  // Walk from oldest (tail-DEPTH) to newest (tail-1); a later hit overrides an
  // earlier one, so the newest match wins.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = '0;
    w_slot = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      w_slot = i_tail - PTR_W'(k);
      if (i_valid[w_slot] && (i_word[w_slot] == i_key)) begin
        o_hit = 1'b1;
        o_idx = w_slot;
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// rtl/dmem_write_buffer.sv - posted-store FIFO between L2 writeback and data memory
// Purpose: queue word stores, drain one per cycle in order with the store opcode,
// and forward pending store data to same-word loads.
// Optional feature: define DMEM_WBUF_COALESCE_EN to merge a push into the newest
// matching non-head entry instead of allocating a new slot.
// Ports:
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_wr_valid/o_wr_ready        store handshake from L2
//   i_wr_addr, i_wr_data         store byte address and data
//   i_ld_addr -> o_ld_hit/o_ld_data  combinational load forwarding
//   i_flush_req, o_flush_done    level drain request, completion pulse
//   o_dmem_opcode/addr/wdata     head entry presented to data memory
//   o_count                      occupied entries
module dmem_write_buffer
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = WBUF_ADDR_W,
  parameter int DATA_W = WBUF_DATA_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic [ADDR_W-1:0]         i_ld_addr,
  output logic                      o_ld_hit,
  output logic [DATA_W-1:0]         o_ld_data,
  input  logic                      i_flush_req,
  output logic                      o_flush_done,
  output logic [6:0]                o_dmem_opcode,
  output logic [ADDR_W-1:0]         o_dmem_addr,
  output logic [DATA_W-1:0]         o_dmem_wdata,
  output logic [$clog2(DEPTH):0]    o_count
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = ADDR_W - 2;

  wbuf_entry_t       r_entry [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  wbuf_state_t       r_state;
  logic              r_flush_done;

  wbuf_state_t                 w_state_nxt;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_coal;
  logic                        w_alloc;
  logic [CNT_W-1:0]            w_count_nxt;
  logic [DEPTH-1:0]            w_valid_vec;
  logic [DEPTH-1:0][WORD_W-1:0] w_words;
  logic                        w_ld_hit;
  logic [PTR_W-1:0]            w_ld_idx;
  logic                        w_unused_ld_lsb;

  assign w_unused_ld_lsb = ^i_ld_addr[1:0];

  always_comb begin
    w_valid_vec = '0;
    w_words     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_valid_vec[i] = r_entry[i].valid;
      w_words[i]     = r_entry[i].addr[ADDR_W-1:2];
    end
  end

  // Forwarding looks at every valid entry, head included.
  wbuf_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_ld_match (
    .i_valid (w_valid_vec),
    .i_word  (w_words),
    .i_tail  (r_tail),
    .i_key   (i_ld_addr[ADDR_W-1:2]),
    .o_hit   (w_ld_hit),
    .o_idx   (w_ld_idx)
  );

`ifdef DMEM_WBUF_COALESCE_EN
  logic [DEPTH-1:0] w_coal_mask;
  logic             w_coal_hit;
  logic [PTR_W-1:0] w_coal_idx;

  // Head is on the memory bus this cycle, so it may not absorb new data.
  assign w_coal_mask = w_valid_vec & ~(DEPTH'(1) << r_head);

  wbuf_match #(
    .DEPTH  (DEPTH),
    .WORD_W (WORD_W)
  ) u_wr_match (
    .i_valid (w_coal_mask),
    .i_word  (w_words),
    .i_tail  (r_tail),
    .i_key   (i_wr_addr[ADDR_W-1:2]),
    .o_hit   (w_coal_hit),
    .o_idx   (w_coal_idx)
  );

  assign w_coal = w_push & w_coal_hit;
`else
  assign w_coal = 1'b0;
`endif

  assign o_wr_ready  = (r_count < CNT_W'(DEPTH)) && (r_state != FLUSH);
  assign w_push      = i_wr_valid & o_wr_ready;
  // Any occupied head is presented to memory and retires at the next edge.
  assign w_pop       = (r_count != '0);
  assign w_alloc     = w_push & ~w_coal;
  assign w_count_nxt = r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_flush_req)  w_state_nxt = FLUSH;
        else if (w_push)  w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (i_flush_req)              w_state_nxt = FLUSH;
        else if (w_count_nxt == '0)   w_state_nxt = IDLE;
      end
      FLUSH: begin
        if (w_count_nxt == '0)        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_state      <= IDLE;
      r_flush_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_entry[i] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_entry[r_head].valid <= 1'b0;
        r_head                <= r_head + PTR_W'(1);
      end
      // A push never lands on head while it pops: wr_ready is low when full.
      if (w_alloc) begin
        r_entry[r_tail] <= '{valid: 1'b1, addr: i_wr_addr, data: i_wr_data};
        r_tail          <= r_tail + PTR_W'(1);
      end
`ifdef DMEM_WBUF_COALESCE_EN
      if (w_coal) begin
        r_entry[w_coal_idx].data <= i_wr_data;
      end
`endif
      r_count      <= w_count_nxt;
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == FLUSH) && (w_count_nxt == '0);
    end
  end

  // Memory outputs derive only from reset registers, so they drop to idle
  // the instant reset asserts.
  assign o_dmem_opcode = w_pop ? OPC_STORE : OPC_NONE;
  assign o_dmem_addr   = w_pop ? r_entry[r_head].addr : '0;
  assign o_dmem_wdata  = w_pop ? r_entry[r_head].data : '0;
  assign o_ld_hit      = w_ld_hit;
  assign o_ld_data     = w_ld_hit ? r_entry[w_ld_idx].data : '0;
  assign o_flush_done  = r_flush_done;
  assign o_count       = r_count;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb/tb_dmem_write_buffer.sv - self-checking bench for dmem_write_buffer
module tb_dmem_write_buffer;

  localparam int DEPTH = 4;
  localparam logic [6:0] ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        flush_req;
  logic        flush_done;
  logic [6:0]  dmem_opcode;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [2:0]  count;

  always #5 clk = ~clk;

  dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_wr_valid    (wr_valid),
    .o_wr_ready    (wr_ready),
    .i_wr_addr     (wr_addr),
    .i_wr_data     (wr_data),
    .i_ld_addr     (ld_addr),
    .o_ld_hit      (ld_hit),
    .o_ld_data     (ld_data),
    .i_flush_req   (flush_req),
    .o_flush_done  (flush_done),
    .o_dmem_opcode (dmem_opcode),
    .o_dmem_addr   (dmem_addr),
    .o_dmem_wdata  (dmem_wdata),
    .o_count       (count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } st_t;

  st_t pq[$];
  st_t exp_mem[$];
  st_t got_mem[$];
  bit  flushing;
  bit  done_exp;
  int  n_tests = 0;
  int  n_fail = 0;
  int  n_done_pulses = 0;

  always @(negedge clk) begin
    if (dmem_opcode == ST) got_mem.push_back('{dmem_addr, dmem_wdata});
    if (flush_done) n_done_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pq.delete();
    flushing = 0;
    done_exp = 0;
  endtask

  task automatic check_outputs();
    bit          hit = 0;
    logic [31:0] hd  = '0;
    for (int i = pq.size() - 1; i >= 0; i--) begin
      if (pq[i].a[31:2] == ld_addr[31:2]) begin
        hit = 1;
        hd  = pq[i].d;
        break;
      end
    end
    chk("wr_ready",   wr_ready,   (pq.size() < DEPTH) && !flushing);
    chk("count",      count,      pq.size());
    chk("ld_hit",     ld_hit,     hit);
    chk("ld_data",    ld_data,    hd);
    chk("flush_done", flush_done, done_exp);
    chk("dmem_opc",   dmem_opcode, (pq.size() > 0) ? ST : 7'd0);
    chk("dmem_addr",  dmem_addr,   (pq.size() > 0) ? pq[0].a : 32'd0);
    chk("dmem_wdata", dmem_wdata,  (pq.size() > 0) ? pq[0].d : 32'd0);
  endtask

  // Applies one rising edge to the reference model using the held inputs.
  task automatic model_update();
    bit ready = (pq.size() < DEPTH) && !flushing;
    bit push  = wr_valid && ready;
    bit coal  = 0;
`ifdef DMEM_WBUF_COALESCE_EN
    if (push) begin
      for (int i = pq.size() - 1; i >= 1; i--) begin
        if (pq[i].a[31:2] == wr_addr[31:2]) begin
          pq[i].d = wr_data;
          coal = 1;
          break;
        end
      end
    end
`endif
    if (pq.size() > 0) exp_mem.push_back(pq.pop_front());
    if (push && !coal) pq.push_back('{wr_addr, wr_data});
    done_exp = 0;
    if (flushing) begin
      if (pq.size() == 0) begin
        flushing = 0;
        done_exp = 1;
      end
    end else if (flush_req) begin
      flushing = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int base;
    int saved;
    rst_n = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; ld_addr = 0; flush_req = 0;
    model_reset();
    #1;
    chk("rst_ready", wr_ready, 1);
    chk("rst_hit",   ld_hit, 0);
    chk("rst_ldd",   ld_data, 0);
    chk("rst_done",  flush_done, 0);
    chk("rst_opc",   dmem_opcode, 0);
    chk("rst_addr",  dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_count", count, 0);
    @(posedge clk); #1;
    rst_n = 1;

    // single store latency
    wr_valid = 1; wr_addr = 32'h100; wr_data = 32'hAAAA0001;
    step();
    wr_valid = 0;
    chk("t1_opc",   dmem_opcode, ST);
    chk("t1_addr",  dmem_addr, 32'h100);
    chk("t1_wdata", dmem_wdata, 32'hAAAA0001);
    step();
    chk("t1_count", count, 0);
    chk("t1_idle",  dmem_opcode, 0);

    // five back-to-back stores, throughput one per cycle
    base = got_mem.size();
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_addr = 32'h200 + 32'(i * 4); wr_data = $urandom;
      step();
      chk("t2_ready", wr_ready, 1);
    end
    wr_valid = 0;
    step(); step();
    chk("t2_nwr", got_mem.size() - base, 5);
    for (int i = 0; i < 5 && base + i < got_mem.size(); i++)
      chk("t2_order", got_mem[base + i].a, 32'h200 + 32'(i * 4));

    // same-word stores with forwarding
    base = got_mem.size();
    wr_valid = 1; wr_addr = 32'h40; wr_data = 32'h1;
    step();
    ld_addr = 32'h42; #1;
    chk("t3_hit1", ld_hit, 1);
    chk("t3_dat1", ld_data, 32'h1);
    wr_addr = 32'h40; wr_data = 32'h2;
    step();
    wr_valid = 0;
    chk("t3_hit2", ld_hit, 1);
    chk("t3_dat2", ld_data, 32'h2);
    step(); step();
    chk("t3_nwr", got_mem.size() - base, 2);
    if (got_mem.size() >= base + 2) begin
      chk("t3_first",  got_mem[base].d, 32'h1);
      chk("t3_second", got_mem[base + 1].d, 32'h2);
    end

    // flush with stores pending
    n_done_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 32'h300 + 32'(i * 4); wr_data = 32'hF00 + 32'(i);
      flush_req = (i == 2);
      step();
    end
    flush_req = 0;
    wr_addr = 32'h3F0; wr_data = 32'hBAD;
    chk("t4_blocked", wr_ready, 0);
    step();
    wr_valid = 0;
    step(); step(); step();
    chk("t4_pulses", n_done_pulses, 1);
    chk("t4_ready", wr_ready, 1);

    // flush of an empty buffer
    flush_req = 1;
    step();
    flush_req = 0;
    chk("t5_notready", wr_ready, 0);
    step();
    chk("t5_done", flush_done, 1);
    chk("t5_ready", wr_ready, 1);
    step();

    // reset asserted while a store is on the memory bus
    wr_valid = 1; wr_addr = 32'h500; wr_data = 32'h55;
    step();
    wr_addr = 32'h504; wr_data = 32'h56;
    step();
    #2 rst_n = 0;
    #1;
    model_reset();
    wr_valid = 0;
    saved = got_mem.size();
    chk("t6_opc",   dmem_opcode, 0);
    chk("t6_addr",  dmem_addr, 0);
    chk("t6_wdata", dmem_wdata, 0);
    chk("t6_count", count, 0);
    chk("t6_ready", wr_ready, 1);
    chk("t6_hit",   ld_hit, 0);
    chk("t6_done",  flush_done, 0);
    @(posedge clk); #1;
    rst_n = 1;
    step(); step(); step();
    chk("t6_nowr", got_mem.size(), saved);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      wr_valid  = ($urandom_range(0, 3) != 0);
      wr_addr   = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      wr_data   = $urandom;
      ld_addr   = 32'h1000 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      flush_req = ($urandom_range(0, 19) == 0);
      step();
    end
    wr_valid = 0; flush_req = 0;
    step(); step(); step();

    chk("mem_len", got_mem.size(), exp_mem.size());
    for (int i = 0; i < exp_mem.size() && i < got_mem.size(); i++) begin
      chk("mem_addr", got_mem[i].a, exp_mem[i].a);
      chk("mem_data", got_mem[i].d, exp_mem[i].d);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
